// File: rtl/spell_pkg.sv
// Shared types and constants for the SPELL memory-side bus masters.
package spell_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

endpackage

// File: rtl/spell_mem_timeout.sv
// Access watchdog: counts enabled cycles and flags the cycle that reaches LIMIT.
module spell_mem_timeout #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 8'h00;
        end else if (clear) begin
            count <= 8'h00;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // Asserted during the LIMIT-th enabled cycle, so exactly LIMIT cycles elapse before abort.
    assign expired = enable && (count >= LIMIT - 8'd1);

endmodule

// File: rtl/spell_mem_arbiter.sv
// Round-robin arbiter between the core's fetch and data ports onto the single memory-router bus.
module spell_mem_arbiter
    import spell_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_req,
    input  logic [7:0] fetch_addr,
    output logic       fetch_ack,
    output logic [7:0] fetch_rdata,
    input  logic       data_req,
    input  logic [7:0] data_addr,
    input  logic       data_write,
    input  logic [7:0] data_wdata,
    output logic       data_ack,
    output logic [7:0] data_rdata,
    output logic       mem_select,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_in,
    output logic       mem_type_data,
    output logic       mem_write,
    input  logic [7:0] mem_data_out,
    input  logic       mem_data_ready,
    output logic       bus_error,
    input  logic       err_clear
);

    arb_state_t state, state_next;
    grant_t     last_grant, grant_next;
    logic       grant_valid;
    logic       busy;
    logic       timed_out;
    logic       finish;
    logic       abort;
    logic [7:0] resp_data;

    assign busy   = (state == BUSY);
    assign finish = busy && (mem_data_ready || timed_out);
    assign abort  = busy && !mem_data_ready && timed_out;

    spell_mem_timeout #(
        .LIMIT(8'(TIMEOUT_CYCLES))
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == RESP),
        .enable (busy),
        .expired(timed_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        grant_next  = last_grant;
        grant_valid = 1'b0;
        resp_data   = mem_write ? 8'h00 : (mem_data_ready ? mem_data_out : ERR_DATA);
        case (state)
            IDLE: begin
                if (fetch_req && data_req) begin
                    grant_valid = 1'b1;
                    grant_next  = (last_grant == GRANT_FETCH) ? GRANT_DATA : GRANT_FETCH;
                end else if (fetch_req) begin
                    grant_valid = 1'b1;
                    grant_next  = GRANT_FETCH;
                end else if (data_req) begin
                    grant_valid = 1'b1;
                    grant_next  = GRANT_DATA;
                end
                if (grant_valid) state_next = BUSY;
            end
            BUSY:    if (finish) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus fields are latched at grant and held untouched until the access completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant    <= GRANT_FETCH;
            mem_select    <= 1'b0;
            mem_type_data <= 1'b0;
            mem_write     <= 1'b0;
            mem_addr      <= 8'h00;
            mem_data_in   <= 8'h00;
            fetch_ack     <= 1'b0;
            data_ack      <= 1'b0;
            fetch_rdata   <= 8'h00;
            data_rdata    <= 8'h00;
            bus_error     <= 1'b0;
        end else begin
            last_grant <= grant_next;
            fetch_ack  <= 1'b0;
            data_ack   <= 1'b0;
            if (grant_valid) begin
                mem_select    <= 1'b1;
                mem_type_data <= (grant_next == GRANT_DATA);
                mem_write     <= (grant_next == GRANT_DATA) && data_write;
                mem_addr      <= (grant_next == GRANT_DATA) ? data_addr : fetch_addr;
                mem_data_in   <= (grant_next == GRANT_DATA) ? data_wdata : 8'h00;
            end
            if (finish) begin
                mem_select    <= 1'b0;
                mem_type_data <= 1'b0;
                mem_write     <= 1'b0;
                if (last_grant == GRANT_DATA) begin
                    data_ack   <= 1'b1;
                    data_rdata <= resp_data;
                end else begin
                    fetch_ack   <= 1'b1;
                    fetch_rdata <= resp_data;
                end
            end
            // A timeout in the same cycle as a clear still leaves the flag set.
            if (abort) begin
                bus_error <= 1'b1;
            end else if (err_clear) begin
                bus_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Self-checking bench for spell_mem_arbiter: directed vectors, corner sequences and a randomized run.
module tb_spell_mem_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fetch_req = 1'b0;
    logic [7:0] fetch_addr = 8'h00;
    logic       fetch_ack;
    logic [7:0] fetch_rdata;
    logic       data_req = 1'b0;
    logic [7:0] data_addr = 8'h00;
    logic       data_write = 1'b0;
    logic [7:0] data_wdata = 8'h00;
    logic       data_ack;
    logic [7:0] data_rdata;
    logic       mem_select;
    logic [7:0] mem_addr;
    logic [7:0] mem_data_in;
    logic       mem_type_data;
    logic       mem_write;
    logic [7:0] mem_data_out = 8'h00;
    logic       mem_data_ready = 1'b0;
    logic       bus_error;
    logic       err_clear = 1'b0;

    always #5 clk = ~clk;

    spell_mem_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA      (8'hFF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_ack     (fetch_ack),
        .fetch_rdata   (fetch_rdata),
        .data_req      (data_req),
        .data_addr     (data_addr),
        .data_write    (data_write),
        .data_wdata    (data_wdata),
        .data_ack      (data_ack),
        .data_rdata    (data_rdata),
        .mem_select    (mem_select),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .mem_type_data (mem_type_data),
        .mem_write     (mem_write),
        .mem_data_out  (mem_data_out),
        .mem_data_ready(mem_data_ready),
        .bus_error     (bus_error),
        .err_clear     (err_clear)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory seen by the bus responder (indexed by the DUT's mem_addr) and the
    // reference copy (indexed by the address the requester asked for).
    logic [7:0] mem_model [256];
    logic [7:0] ref_mem   [256];

    // Independent monitors: ack pulse counts and mem_select low-gap lengths.
    int f_acks = 0;
    int d_acks = 0;
    int low_run = 0;
    logic prev_sel = 1'b0;
    int gaps[$];

    always @(negedge clk) begin
        if (fetch_ack) f_acks++;
        if (data_ack)  d_acks++;
        if (mem_select && !prev_sel) gaps.push_back(low_run);
        if (mem_select) low_run = 0;
        else            low_run++;
        prev_sel = mem_select;
    end

    typedef struct {
        logic       is_data;
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       preload;
        logic [7:0] load_val;
        int         delay;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays the router: waits for a grant, holds ready low for 'delay' BUSY cycles,
    // then raises it. Returns once mem_select has dropped (DUT in its ack cycle).
    task automatic serve(input string name, input int delay, output int busy,
                         output logic [7:0] s_addr, output logic s_write,
                         output logic s_type, output logic [7:0] s_wdata);
        int   w = 0;
        logic stable = 1'b1;
        busy = 0;
        s_addr = 8'h00; s_write = 1'b0; s_type = 1'b0; s_wdata = 8'h00;
        while (!mem_select && w < 10) begin
            tick();
            w++;
        end
        check({name, ".select_rise"}, 32'(mem_select), 32'd1);
        if (!mem_select) return;
        s_addr = mem_addr; s_write = mem_write; s_type = mem_type_data; s_wdata = mem_data_in;
        while (mem_select && busy < 50) begin
            busy++;
            if (mem_addr !== s_addr || mem_write !== s_write ||
                mem_type_data !== s_type || mem_data_in !== s_wdata) stable = 1'b0;
            mem_data_out   = mem_model[mem_addr];
            mem_data_ready = (busy == delay + 1);
            if (mem_data_ready && mem_write) mem_model[mem_addr] = mem_data_in;
            tick();
            mem_data_ready = 1'b0;
        end
        check({name, ".bus_stable"}, 32'(stable), 32'd1);
    endtask

    task automatic do_one(input string name, input logic is_d, input logic wr,
                          input logic [7:0] addr, input logic [7:0] wdata, input int delay,
                          input logic [7:0] exp_rd, input logic exp_err);
        int         busy, f0, d0;
        logic [7:0] sa, sw;
        logic       swr, sty;
        f0 = f_acks;
        d0 = d_acks;
        if (is_d) begin
            data_req = 1'b1; data_addr = addr; data_write = wr; data_wdata = wdata;
        end else begin
            fetch_req = 1'b1; fetch_addr = addr;
        end
        serve(name, delay, busy, sa, swr, sty, sw);
        check({name, ".busy_cycles"}, 32'(busy), 32'(delay < TO ? delay + 1 : TO));
        check({name, ".mem_addr"}, 32'(sa), 32'(addr));
        check({name, ".mem_type"}, 32'(sty), 32'(is_d));
        check({name, ".mem_write"}, 32'(swr), 32'(is_d && wr));
        if (is_d && wr) check({name, ".mem_data_in"}, 32'(sw), 32'(wdata));
        check({name, ".ack"}, 32'(is_d ? data_ack : fetch_ack), 32'd1);
        check({name, ".other_ack"}, 32'(is_d ? fetch_ack : data_ack), 32'd0);
        check({name, ".rdata"}, 32'(is_d ? data_rdata : fetch_rdata), 32'(exp_rd));
        check({name, ".bus_error"}, 32'(bus_error), 32'(exp_err));
        fetch_req = 1'b0;
        data_req  = 1'b0;
        tick(); tick(); tick();
        check({name, ".fetch_ack_count"}, 32'(f_acks - f0), 32'(!is_d));
        check({name, ".data_ack_count"}, 32'(d_acks - d0), 32'(is_d));
        check({name, ".rdata_hold"}, 32'(is_d ? data_rdata : fetch_rdata), 32'(exp_rd));
        check({name, ".bus_error_sticky"}, 32'(bus_error), 32'(exp_err));
        if (exp_err) begin
            err_clear = 1'b1;
            tick();
            err_clear = 1'b0;
            check({name, ".err_cleared"}, 32'(bus_error), 32'd0);
        end
    endtask

    task automatic check_reset_values(input string name);
        check({name, ".mem_select"}, 32'(mem_select), 32'd0);
        check({name, ".mem_ctl"}, {30'd0, mem_write, mem_type_data}, 32'd0);
        check({name, ".mem_addr"}, 32'(mem_addr), 32'd0);
        check({name, ".mem_data_in"}, 32'(mem_data_in), 32'd0);
        check({name, ".acks"}, {30'd0, fetch_ack, data_ack}, 32'd0);
        check({name, ".rdata"}, {16'd0, fetch_rdata, data_rdata}, 32'd0);
        check({name, ".bus_error"}, 32'(bus_error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = 8'($urandom);
            ref_mem[i]   = mem_model[i];
        end

        // is_data write addr wdata preload load_val delay exp_rdata exp_err
        vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, 2,  8'hA5, 1'b0}; // plain fetch
        vecs[1] = '{1'b1, 1'b1, 8'h21, 8'h3C, 1'b0, 8'h00, 1,  8'h00, 1'b0}; // IO store
        vecs[2] = '{1'b1, 1'b0, 8'h21, 8'h00, 1'b0, 8'h00, 0,  8'h3C, 1'b0}; // read back store
        vecs[3] = '{1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 8'h77, 99, 8'hFF, 1'b1}; // load timeout
        vecs[4] = '{1'b0, 1'b0, 8'h80, 8'h00, 1'b1, 8'h5A, 3,  8'h5A, 1'b0}; // ready on last cycle
        vecs[5] = '{1'b1, 1'b1, 8'h30, 8'h11, 1'b1, 8'h22, 99, 8'h00, 1'b1}; // store timeout
        vecs[6] = '{1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 8'h00, 0,  8'h22, 1'b0}; // timed-out store not written
        vecs[7] = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 0,  8'h00, 1'b0}; // fastest fetch

        rst_n = 1'b0;
        tick(); tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            if (vecs[i].preload) begin
                mem_model[vecs[i].addr] = vecs[i].load_val;
                ref_mem[vecs[i].addr]   = vecs[i].load_val;
            end
            do_one($sformatf("vec%0d", i), vecs[i].is_data, vecs[i].write, vecs[i].addr,
                   vecs[i].wdata, vecs[i].delay, vecs[i].exp_rdata, vecs[i].exp_err);
        end
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_data && vecs[i].write && vecs[i].delay < TO)
                ref_mem[vecs[i].addr] = vecs[i].wdata;
        end

        // Randomized single-port accesses against the reference memory.
        for (int i = 0; i < 40; i++) begin
            logic       is_d, wr, exp_e;
            logic [7:0] a, wd, exp_r;
            int         dl;
            is_d  = 1'($urandom_range(0, 1));
            wr    = is_d && ($urandom_range(0, 1) == 1);
            a     = 8'($urandom);
            wd    = 8'($urandom);
            dl    = $urandom_range(0, 5);
            exp_e = (dl >= TO);
            if (wr)         exp_r = 8'h00;
            else if (exp_e) exp_r = 8'hFF;
            else            exp_r = ref_mem[a];
            do_one($sformatf("rnd%0d", i), is_d, wr, a, wd, dl, exp_r, exp_e);
            if (wr && !exp_e) ref_mem[a] = wd;
        end

        // Reset in the middle of a BUSY fetch: no ack, outputs back to reset values.
        begin
            int         f0, busy, w;
            logic [7:0] sa, sw;
            logic       swr, sty;
            f0 = f_acks;
            mem_model[8'h44] = 8'hC3;
            fetch_req = 1'b1; fetch_addr = 8'h44;
            w = 0;
            while (!mem_select && w < 10) begin tick(); w++; end
            tick();
            rst_n = 1'b0;
            tick();
            check_reset_values("midreset");
            rst_n = 1'b1;
            check("midreset.no_ack", 32'(f_acks - f0), 32'd0);
            serve("reissue", 0, busy, sa, swr, sty, sw);
            check("reissue.mem_addr", 32'(sa), 32'h44);
            check("reissue.ack", 32'(fetch_ack), 32'd1);
            check("reissue.rdata", 32'(fetch_rdata), 32'hC3);
            fetch_req = 1'b0;
            tick(); tick();
            check("reissue.ack_count", 32'(f_acks - f0), 32'd1);
        end

        // Both ports pending from reset: DATA, FETCH, DATA with >=2 idle cycles between.
        begin
            int         f0, d0, busy, g0;
            logic [7:0] sa, sw;
            logic       swr, sty;
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            mem_model[8'h01] = 8'h91; mem_model[8'h02] = 8'h92; mem_model[8'h03] = 8'h93;
            f0 = f_acks; d0 = d_acks; g0 = gaps.size();
            fetch_req = 1'b1; fetch_addr = 8'h01;
            data_req  = 1'b1; data_addr  = 8'h02; data_write = 1'b0;
            serve("rr1", 1, busy, sa, swr, sty, sw);
            check("rr1.type", 32'(sty), 32'd1);
            check("rr1.addr", 32'(sa), 32'h02);
            check("rr1.data_ack", {30'd0, data_ack, fetch_ack}, 32'd2);
            check("rr1.rdata", 32'(data_rdata), 32'h92);
            data_addr = 8'h03;
            serve("rr2", 0, busy, sa, swr, sty, sw);
            check("rr2.type", 32'(sty), 32'd0);
            check("rr2.addr", 32'(sa), 32'h01);
            check("rr2.fetch_ack", {30'd0, data_ack, fetch_ack}, 32'd1);
            check("rr2.rdata", 32'(fetch_rdata), 32'h91);
            fetch_req = 1'b0;
            serve("rr3", 2, busy, sa, swr, sty, sw);
            check("rr3.type", 32'(sty), 32'd1);
            check("rr3.addr", 32'(sa), 32'h03);
            check("rr3.data_ack", {30'd0, data_ack, fetch_ack}, 32'd2);
            check("rr3.rdata", 32'(data_rdata), 32'h93);
            data_req = 1'b0;
            tick(); tick(); tick();
            check("rr.fetch_acks", 32'(f_acks - f0), 32'd1);
            check("rr.data_acks", 32'(d_acks - d0), 32'd2);
            check("rr.grants", 32'(gaps.size() - g0), 32'd3);
            for (int i = g0; i < gaps.size(); i++)
                check($sformatf("rr.gap%0d", i - g0), 32'(gaps[i] >= 2), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spell_mem_arbiter.md
Name: spell_mem_arbiter

Overview:
Upstream neighbour of the SPELL memory router: arbitrates between the core's instruction-fetch port and its data load/store port and drives the router's single select/addr/write/data_ready bus. Serialises accesses, holds the bus stable until data_ready, returns read data through a one-cycle ack pulse, and times out hung accesses. Sits between spell_core and spell_mem.

Parameters:
TIMEOUT_CYCLES, 255, max BUSY cycles without mem_data_ready before abort; legal range 1..255.
ERR_DATA, 8'hFF, read data returned on a timed-out access.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
fetch_req  input  1  code-read request, level, held until fetch_ack
fetch_addr  input  8  code address
fetch_ack  output  1  one-cycle pulse, fetch_rdata valid
fetch_rdata  output  8  fetched byte
data_req  input  1  data-access request, level, held until data_ack
data_addr  input  8  data address (0x20-0x5F is IO space inside the router)
data_write  input  1  1 = store, 0 = load
data_wdata  input  8  store data
data_ack  output  1  one-cycle pulse, data_rdata valid
data_rdata  output  8  loaded byte; 8'h00 after a store
mem_select  output  1  to router select
mem_addr  output  8  to router addr
mem_data_in  output  8  to router data_in
mem_type_data  output  1  to router memory_type_data (1 = data access)
mem_write  output  1  to router write
mem_data_out  input  8  from router data_out
mem_data_ready  input  1  from router data_ready
bus_error  output  1  sticky timeout flag
err_clear  input  1  clears bus_error

Behaviour:
- Reset (clk edge with rst_n=0, including mid-access): state IDLE; mem_select, mem_write, mem_type_data, fetch_ack, data_ack, bus_error = 0; mem_addr, mem_data_in, fetch_rdata, data_rdata = 8'h00; last_grant = FETCH; timeout counter = 0. The aborted access is never acked.
- FSM: IDLE -> BUSY -> RESP -> IDLE.
- IDLE: all mem_* control low. If either req is high, latch the winner's addr/write/wdata into mem_* registers, set mem_type_data (1 for data port, 0 for fetch, mem_write forced 0 for fetch), go to BUSY.
- Arbitration: single request wins. Both pending: grant the port opposite to last_grant (round-robin); update last_grant on every grant. No starvation: a pending port waits at most one foreign access.
- BUSY: mem_select=1; mem_addr/mem_data_in/mem_write/mem_type_data stable throughout. Counter increments each BUSY cycle.
  - mem_data_ready sampled 1: capture mem_data_out (loads and fetches) or 8'h00 (stores) into the granted port's rdata; go to RESP.
  - Counter reaches TIMEOUT_CYCLES with no ready: capture ERR_DATA (8'h00 for a store), set bus_error, go to RESP.
  - Ready and timeout in the same cycle: ready wins, no error.
- RESP: mem_select=0; granted port's ack=1 for exactly this cycle; counter cleared; next state IDLE.
- Minimum access: request seen in IDLE cycle N; mem_select high N+1; ready in N+1 gives ack in N+2; next grant earliest in N+4 (mem_select low for at least two cycles between accesses).
- rdata registers hold their value until the next ack on the same port.
- Requester must drop req or present a new request by the cycle after ack; the arbiter samples req only in IDLE.
- bus_error: set on timeout; cleared by err_clear in any cycle. If set and clear coincide, set wins.
- mem_data_ready outside BUSY is ignored.

Decomposition:
- Shared package spell_pkg: arbiter state enum (IDLE, BUSY, RESP), grant enum (GRANT_FETCH, GRANT_DATA), default ERR_DATA constant.
- One sub-module: spell_mem_timeout (8-bit counter with clear/enable and an expired output), reusable by other bus masters.

Test Plan:
- Fetch only: fetch_addr=8'h10, memory readies after 3 cycles with 8'hA5 -> mem_type_data=0, mem_write=0, fetch_ack pulses once, fetch_rdata=8'hA5, data_ack never asserted.
- Data store to IO: data_addr=8'h21, wdata=8'h3C -> mem_select/mem_write/mem_type_data=1 with addr 8'h21 held until ready; data_ack pulses once; data_rdata=8'h00.
- Simultaneous requests twice in a row from reset (last_grant=FETCH) -> first grant DATA, then FETCH, then DATA; each ack pulses once, and mem_select drops for at least 2 cycles between accesses.
- Timeout with TIMEOUT_CYCLES=4 and data_ready held 0 on a load -> exactly 4 BUSY cycles; data_ack with 8'hFF; bus_error=1 until err_clear; a following normal access succeeds.
- Ready on the final timeout cycle -> real data returned, bus_error stays 0.
- rst_n pulsed low mid-BUSY -> next cycle mem_select=0 and all outputs at reset values, no ack; a re-issued request completes normally.
